// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared keypad codes, widths and event FSM state type
package keypad_pkg;

  localparam int KEYCODE_W = 8;
  localparam logic [KEYCODE_W-1:0] KEY_NONE = 8'h00;

  typedef enum logic {
    IDLE,
    HELD
  } key_state_t;

endpackage

// File: rtl/key_event_queue_if.sv
// rtl/key_event_queue_if.sv - valid/ready key event stream between queue and consumer
interface key_event_queue_if;
  import keypad_pkg::*;

  logic [KEYCODE_W-1:0] out_code;
  logic                 out_valid;
  logic                 out_ready;

  modport master (
    output out_code,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_code,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock first-word-fall-through FIFO, power-of-two depth
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  // A pop on the same edge frees the slot, so a full FIFO still accepts the push.
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/key_event_queue.sv
// rtl/key_event_queue.sv - debounced keycode to press-event FIFO; KEY_REPEAT_EN adds auto-repeat
module key_event_queue
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int FIFO_DEPTH      = 8,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [KEYCODE_W-1:0]          keycode,
  key_event_queue_if.master             evt,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          overflow,
  input  logic                          clr_ovf
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [KEYCODE_W-1:0] cand;
  logic [CNT_W-1:0]     cnt;
  logic [KEYCODE_W-1:0] stable;
  logic [KEYCODE_W-1:0] stable_d;
  key_state_t           state;
  logic                 push;
  logic [KEYCODE_W-1:0] push_code;
  logic [KEYCODE_W-1:0] head;
  logic                 full;
  logic                 empty;
  logic                 pop;
  logic                 drop;

  // The FSM looks at the value stable is about to take so the event is queued one edge later.
  assign stable_d = (keycode == cand && cnt == CNT_MAX) ? cand : stable;

  always_ff @(posedge clk) begin
    if (rst) begin
      cand   <= KEY_NONE;
      cnt    <= '0;
      stable <= KEY_NONE;
    end else begin
      if (keycode != cand) begin
        cand <= keycode;
        cnt  <= '0;
      end else if (cnt != CNT_MAX) begin
        cnt <= cnt + 1'b1;
      end
      stable <= stable_d;
    end
  end

`ifdef KEY_REPEAT_EN
  logic [31:0] rpt_cnt;
  logic        rpt_first;
  logic [31:0] rpt_limit;

  assign rpt_limit = rpt_first ? 32'(REPEAT_DELAY) : 32'(REPEAT_RATE);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      push      <= 1'b0;
      push_code <= KEY_NONE;
`ifdef KEY_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
    end else begin
      push <= 1'b0;
`ifdef KEY_REPEAT_EN
      rpt_cnt   <= '0;
      rpt_first <= 1'b1;
`endif
      case (state)
        IDLE: begin
          if (stable_d != KEY_NONE) begin
            push      <= 1'b1;
            push_code <= stable_d;
            state     <= HELD;
          end
        end
        HELD: begin
          if (stable_d == KEY_NONE) begin
            state <= IDLE;
          end else if (stable_d != stable) begin
            push      <= 1'b1;
            push_code <= stable_d;
          end else begin
`ifdef KEY_REPEAT_EN
            if (rpt_cnt == rpt_limit - 32'd1) begin
              push      <= 1'b1;
              push_code <= stable;
              rpt_first <= 1'b0;
            end else begin
              rpt_cnt   <= rpt_cnt + 32'd1;
              rpt_first <= rpt_first;
            end
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign pop  = evt.out_valid && evt.out_ready;
  assign drop = push && full && !pop;

  sync_fifo #(
    .WIDTH (KEYCODE_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (push_code),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign evt.out_valid = !empty;
  assign evt.out_code  = empty ? KEY_NONE : head;

  // A drop on the same edge as a clear must leave the flag set.
  always_ff @(posedge clk) begin
    if (rst)          overflow <= 1'b0;
    else if (drop)    overflow <= 1'b1;
    else if (clr_ovf) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_key_event_queue.sv
// tb/tb_key_event_queue.sv - scoreboard bench for key_event_queue
module tb_key_event_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] keycode;
  logic [2:0] count;
  logic       overflow;
  logic       clr_ovf;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];

  key_event_queue_if ifc ();

  key_event_queue #(
    .DEBOUNCE_CYCLES (4),
    .FIFO_DEPTH      (4),
    .REPEAT_DELAY    (40),
    .REPEAT_RATE     (20)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .keycode  (keycode),
    .evt      (ifc.master),
    .count    (count),
    .overflow (overflow),
    .clr_ovf  (clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready) begin
      if (exp_q.size() == 0) chk("sb_extra_event", 32'(exp_q.size()), 1);
      else                   chk("event_code", 32'(ifc.out_code), 32'(exp_q.pop_front()));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [7:0] code, input int n_hold, input int n_rel);
    keycode = code;
    cycles(n_hold);
    keycode = 8'h00;
    cycles(n_rel);
  endtask

  task automatic drain(input int n);
    ifc.out_ready = 1'b1;
    cycles(n);
    ifc.out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    keycode = 8'h00;
    clr_ovf = 1'b0;
    ifc.out_ready = 1'b0;
    cycles(3);
    chk("rst_valid", 32'(ifc.out_valid), 0);
    chk("rst_code", 32'(ifc.out_code), 0);
    chk("rst_count", 32'(count), 0);
    chk("rst_ovf", 32'(overflow), 0);
    rst = 1'b0;
    cycles(3);

    // clean press and latency
    exp_q.push_back(8'h12);
    keycode = 8'h12;
    cycles(5);
    chk("lat_early", 32'(ifc.out_valid), 0);
    cycles(1);
    chk("lat_valid", 32'(ifc.out_valid), 1);
    chk("lat_code", 32'(ifc.out_code), 32'h12);
    cycles(4);
    keycode = 8'h00;
    cycles(8);
    chk("clean_count", 32'(count), 1);
    drain(3);
    chk("clean_drained", 32'(count), 0);

    // glitch rejection
    press(8'h21, 3, 8);
    chk("glitch_count", 32'(count), 0);
    chk("glitch_valid", 32'(ifc.out_valid), 0);

    // rollover
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h14);
    keycode = 8'h11;
    cycles(8);
    press(8'h14, 8, 8);
    chk("roll_count", 32'(count), 2);
    drain(4);
    chk("roll_drained", 32'(count), 0);

    // overflow
    for (int i = 1; i <= 5; i++) begin
      if (i <= 4) exp_q.push_back(8'(i));
      press(8'(i), 6, 6);
    end
    chk("ovf_count", 32'(count), 4);
    chk("ovf_flag", 32'(overflow), 1);
    chk("ovf_head", 32'(ifc.out_code), 32'h01);
    clr_ovf = 1'b1;
    cycles(1);
    clr_ovf = 1'b0;
    chk("ovf_cleared", 32'(overflow), 0);
    drain(6);
    chk("ovf_drained", 32'(count), 0);

    // full with simultaneous pop and push
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(8'h31 + 8'(i));
      press(8'h31 + 8'(i), 6, 6);
    end
    chk("full_count", 32'(count), 4);
    exp_q.push_back(8'h35);
    keycode = 8'h35;
    cycles(5);
    ifc.out_ready = 1'b1;
    cycles(1);
    ifc.out_ready = 1'b0;
    chk("pp_count", 32'(count), 4);
    chk("pp_ovf", 32'(overflow), 0);
    chk("pp_head", 32'(ifc.out_code), 32'h32);
    keycode = 8'h00;
    cycles(6);
    drain(6);
    chk("pp_drained", 32'(count), 0);

    // reset while a key is held
    exp_q.push_back(8'h41);
    exp_q.push_back(8'h12);
    press(8'h41, 6, 6);
    keycode = 8'h12;
    cycles(8);
    chk("mid_count", 32'(count), 2);
    rst = 1'b1;
    cycles(2);
    chk("mid_rst_count", 32'(count), 0);
    chk("mid_rst_valid", 32'(ifc.out_valid), 0);
    exp_q.delete();
    rst = 1'b0;
    exp_q.push_back(8'h12);
    cycles(10);
    chk("mid_after_count", 32'(count), 1);
    chk("mid_after_code", 32'(ifc.out_code), 32'h12);
    drain(3);
    keycode = 8'h00;
    cycles(6);
    chk("final_count", 32'(count), 0);
    chk("sb_left", 32'(exp_q.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
